stress_state_controller: RTL and testbench
==========================================

// Module: stress_state_controller
//
// PURPOSE
// Consumer end of the stress_inc/stress_dec request interface produced by the stress regulator.
// - Integrates requests, once per prescaled tick, into a saturating stress level.
// - Derives a 4-state mood state from the level, with hysteresis.
// - Returns one-cycle state_controller_inc/dec pulses to the regulator whenever the level moves.
//
// PARAMETERS
// WIDTH         8    stress level width
// MAX_LEVEL     255  saturation ceiling (<= 2**WIDTH-1)
// TICK_DIV      16   clk cycles per update tick (>= 2)
// TH_TENSE      64   level at which CALM enters TENSE
// TH_STRESSED   128  level at which TENSE enters STRESSED
// TH_PANIC      224  level at which STRESSED enters PANIC
// HYST          8    downward hysteresis margin (< TH_TENSE)
// DECAY_PERIOD  4    idle ticks per automatic decay step (STRESS_DECAY_EN only)
//
// PORTS
// clk                   in   1      system clock, rising edge
// rst                   in   1      synchronous reset, active-high
// stress_inc            in   1      request: raise stress (level or pulse)
// stress_dec            in   1      request: lower stress (level or pulse)
// level                 out  WIDTH  current stress level
// state                 out  2      0=CALM 1=TENSE 2=STRESSED 3=PANIC
// state_controller_inc  out  1      1-cycle pulse: level incremented
// state_controller_dec  out  1      1-cycle pulse: level decremented
// tick                  out  1      1-cycle update strobe
//
// BEHAVIOUR
// - Clocking: single clock domain. Reset is synchronous, active-high. All flops update on the rising edge of clk.
// - Reset values: level=0, state=CALM, tick=0, state_controller_inc=0, state_controller_dec=0.
//   Reset also clears the prescaler, both pending flags and the decay counter.
//   A reset asserted mid-operation discards any pending request.
// - Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where count==TICK_DIV-1.
// - Pending flags:
//   - pend_inc/pend_dec are set in any cycle where stress_inc/stress_dec is high.
//   - Both flags are cleared on the tick cycle.
//   - A request arriving in the tick cycle itself counts towards that tick.
// - Level update, applied at the clock edge ending the tick cycle:
//   - inc only and level<MAX_LEVEL: level+1.
//   - dec only and level>0: level-1.
//   - Both set, neither set, or saturated: no change.
//   - Level never wraps: 0 stays 0 on dec, MAX_LEVEL stays MAX_LEVEL on inc.
// - Feedback pulses:
//   - state_controller_inc is high for exactly 1 cycle, the cycle after the tick, iff level incremented.
//   - state_controller_dec behaves the same for a decrement.
//   - The two pulses are never high together.
//   - No pulse is issued when the level is blocked by saturation.
// - State FSM (registered; evaluates the registered level, so it lags level by 1 cycle; moves at most one step per cycle):
//   - CALM->TENSE when level>=TH_TENSE.
//   - TENSE->STRESSED when level>=TH_STRESSED.
//   - STRESSED->PANIC when level>=TH_PANIC.
//   - PANIC->STRESSED when level<TH_PANIC-HYST.
//   - STRESSED->TENSE when level<TH_STRESSED-HYST.
//   - TENSE->CALM when level<TH_TENSE-HYST.
//   - Otherwise the state holds.
//
// CONFIGURATION
// STRESS_DECAY_EN defined:
// - A decay counter counts ticks on which neither pending flag is set.
// - Any tick with a request pending resets the counter to 0.
// - On the DECAY_PERIOD-th consecutive idle tick, if level>0, level decrements, state_controller_dec pulses, and the counter resets.
// STRESS_DECAY_EN undefined:
// - No decay logic is built; the level changes only on requests.
//
// TESTING
// 1. rst=1 for 2 cycles -> level=0, state=CALM, tick=0, both feedback pulses=0.
// 2. stress_inc 1-cycle pulse at prescaler count 3 -> level=1 after the next tick;
//    state_controller_inc high for exactly 1 cycle after that tick.
// 3. stress_inc and stress_dec both held for 3 ticks at level=10 -> level stays 10, no feedback pulses.
// 4. stress_inc held until level=64 -> state=TENSE 1 cycle later;
//    then stress_dec to level 57 -> TENSE holds; level 55 -> CALM.
// 5. Saturation: level=255 with stress_inc held -> level stays 255, no inc pulse.
//    Level=0 with stress_dec -> stays 0, no dec pulse.
// 6. STRESS_DECAY_EN, level=5, no requests -> level 4 after tick 4 with dec pulse;
//    a stress_inc before tick 4 restarts the count.

Source files
------------

// File: rtl/stress_state_controller.sv
// Stress level integrator with prescaled update tick, hysteretic mood FSM and inc/dec feedback pulses.
// Optional idle decay of the level is built when STRESS_DECAY_EN is defined.
module stress_state_controller #(
  parameter int WIDTH        = 8,
  parameter int MAX_LEVEL    = 255,
  parameter int TICK_DIV     = 16,
  parameter int TH_TENSE     = 64,
  parameter int TH_STRESSED  = 128,
  parameter int TH_PANIC     = 224,
  parameter int HYST         = 8,
  parameter int DECAY_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stress_inc,
  input  logic             stress_dec,
  output logic [WIDTH-1:0] level,
  output logic [1:0]       state,
  output logic             state_controller_inc,
  output logic             state_controller_dec,
  output logic             tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0]    C_LAST = CW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MAX_LEVEL);
  localparam logic [WIDTH-1:0] L_T    = WIDTH'(TH_TENSE);
  localparam logic [WIDTH-1:0] L_S    = WIDTH'(TH_STRESSED);
  localparam logic [WIDTH-1:0] L_P    = WIDTH'(TH_PANIC);
  localparam logic [WIDTH-1:0] L_T_LO = WIDTH'(TH_TENSE - HYST);
  localparam logic [WIDTH-1:0] L_S_LO = WIDTH'(TH_STRESSED - HYST);
  localparam logic [WIDTH-1:0] L_P_LO = WIDTH'(TH_PANIC - HYST);

  typedef enum logic [1:0] {
    CALM     = 2'd0,
    TENSE    = 2'd1,
    STRESSED = 2'd2,
    PANIC    = 2'd3
  } state_t;

  logic [CW-1:0]    r_cnt;
  logic             r_pend_inc;
  logic             r_pend_dec;
  logic [WIDTH-1:0] r_level;
  logic             r_sc_inc;
  logic             r_sc_dec;
  state_t           r_state;

  logic w_tick;
  logic w_req_inc;
  logic w_req_dec;
  logic w_up;
  logic w_dn;
  logic w_decay_dn;

  assign w_tick    = (r_cnt == C_LAST);
  // A request seen in the tick cycle itself joins that tick's decision.
  assign w_req_inc = r_pend_inc | stress_inc;
  assign w_req_dec = r_pend_dec | stress_dec;
  assign w_up      = w_req_inc & ~w_req_dec & (r_level != L_MAX);
  assign w_dn      = (w_req_dec & ~w_req_inc & (r_level != '0))
                   | w_decay_dn;

`ifdef STRESS_DECAY_EN
  localparam int DW = $clog2(DECAY_PERIOD + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DECAY_PERIOD - 1);

  logic [DW-1:0] r_decay;
  logic          w_idle;
  logic          w_decay_hit;

  assign w_idle      = ~w_req_inc & ~w_req_dec;
  assign w_decay_hit = w_idle & (r_decay == D_LAST);
  assign w_decay_dn  = w_decay_hit & (r_level != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_decay <= '0;
    end else if (w_tick) begin
      if (!w_idle || w_decay_hit) begin
        r_decay <= '0;
      end else begin
        r_decay <= r_decay + 1'b1;
      end
    end
  end
`else
  assign w_decay_dn = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_pend_inc <= 1'b0;
      r_pend_dec <= 1'b0;
      r_level    <= '0;
      r_sc_inc   <= 1'b0;
      r_sc_dec   <= 1'b0;
    end else begin
      r_sc_inc <= 1'b0;
      r_sc_dec <= 1'b0;
      if (w_tick) begin
        r_cnt      <= '0;
        r_pend_inc <= 1'b0;
        r_pend_dec <= 1'b0;
        if (w_up) begin
          r_level  <= r_level + 1'b1;
          r_sc_inc <= 1'b1;
        end else if (w_dn) begin
          r_level  <= r_level - 1'b1;
          r_sc_dec <= 1'b1;
        end
      end else begin
        r_cnt      <= r_cnt + 1'b1;
        r_pend_inc <= r_pend_inc | stress_inc;
        r_pend_dec <= r_pend_dec | stress_dec;
      end
    end
  end

  // Thresholds are ordered, so at most one branch per state can fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CALM;
    end else begin
      unique case (r_state)
        CALM: begin
          if (r_level >= L_T) r_state <= TENSE;
        end
        TENSE: begin
          if (r_level >= L_S)         r_state <= STRESSED;
          else if (r_level < L_T_LO)  r_state <= CALM;
        end
        STRESSED: begin
          if (r_level >= L_P)         r_state <= PANIC;
          else if (r_level < L_S_LO)  r_state <= TENSE;
        end
        PANIC: begin
          if (r_level < L_P_LO) r_state <= STRESSED;
        end
        default: r_state <= CALM;
      endcase
    end
  end

  assign level                = r_level;
  assign state                = r_state;
  assign state_controller_inc = r_sc_inc;
  assign state_controller_dec = r_sc_dec;
  assign tick                 = w_tick;

endmodule

// File: tb/tb_stress_state_controller.sv
// Scoreboard bench for stress_state_controller: directed phases plus randomized traffic.
// Expected tick outcomes come from a per-tick arithmetic model of the level/mood rules.
`timescale 1ns/1ps
module tb_stress_state_controller;

  localparam int W    = 8;
  localparam int MAXL = 255;
  localparam int TD   = 16;
  localparam int THT  = 64;
  localparam int THS  = 128;
  localparam int THP  = 224;
  localparam int HY   = 8;
  localparam int DP   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_inc = 1'b0;
  logic         s_dec = 1'b0;
  logic [W-1:0] level;
  logic [1:0]   state;
  logic         sc_inc;
  logic         sc_dec;
  logic         tick;

  stress_state_controller #(
    .WIDTH(W), .MAX_LEVEL(MAXL), .TICK_DIV(TD),
    .TH_TENSE(THT), .TH_STRESSED(THS), .TH_PANIC(THP),
    .HYST(HY), .DECAY_PERIOD(DP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stress_inc(s_inc),
    .stress_dec(s_dec),
    .level(level),
    .state(state),
    .state_controller_inc(sc_inc),
    .state_controller_dec(sc_dec),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    int inc;
    int dec;
    int st;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model state
  int ph, mlvl, mst, midle;
  bit mpi, mpd;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  function automatic int next_mood(input int s, input int l);
    case (s)
      0: return (l >= THT) ? 1 : 0;
      1: return (l >= THS) ? 2 : ((l < THT - HY) ? 0 : 1);
      2: return (l >= THP) ? 3 : ((l < THS - HY) ? 1 : 2);
      default: return (l < THP - HY) ? 2 : 3;
    endcase
  endfunction

  task automatic model_reset();
    ph = 0; mlvl = 0; mst = 0; midle = 0; mpi = 0; mpd = 0;
  endtask

  task automatic run_cycle(input bit a, input bit b);
    exp_t e;
    bit ei, ed;
    s_inc = a;
    s_dec = b;
    chk("tick", int'(tick), (ph == TD - 1) ? 1 : 0);
    if (ph == TD - 1) begin
      ei = mpi | a;
      ed = mpd | b;
      e.inc = 0;
      e.dec = 0;
      if (ei && !ed && mlvl < MAXL) begin
        mlvl++; e.inc = 1;
      end else if (ed && !ei && mlvl > 0) begin
        mlvl--; e.dec = 1;
      end
`ifdef STRESS_DECAY_EN
      if (ei || ed) midle = 0;
      else begin
        midle++;
        if (midle == DP) begin
          midle = 0;
          if (mlvl > 0) begin mlvl--; e.dec = 1; end
        end
      end
`endif
      mst = next_mood(mst, mlvl);
      e.lvl = mlvl;
      e.st = mst;
      q.push_back(e);
      mpi = 0;
      mpd = 0;
    end else begin
      mpi = mpi | a;
      mpd = mpd | b;
    end
    @(posedge clk);
    #1;
    ph = (ph + 1) % TD;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0);
  endtask

  task automatic drive_until(input bit a, input bit b, input int target);
    int n = 0;
    while (mlvl != target && n < 6000) begin
      run_cycle(a, b);
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_inc = 1'b0;
    s_dec = 1'b0;
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_level", int'(level), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_sc_inc", int'(sc_inc), 0);
    chk("rst_sc_dec", int'(sc_dec), 0);
  endtask

  // Monitor: tick marks that the next cycle presents a new level and pulse.
  bit   prev_tick = 0;
  bit   st_chk = 0;
  int   st_exp = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_tick = 0;
      st_chk = 0;
    end else begin
      chk("pulse_excl", int'(sc_inc & sc_dec), 0);
      if (st_chk) begin
        chk("state", int'(state), st_exp);
        st_chk = 0;
      end
      if (prev_tick) begin
        if (q.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = q.pop_front();
          chk("level", int'(level), e.lvl);
          chk("sc_inc", int'(sc_inc), e.inc);
          chk("sc_dec", int'(sc_dec), e.dec);
          st_exp = e.st;
          st_chk = 1;
        end
      end else begin
        chk("sc_inc_idle", int'(sc_inc), 0);
        chk("sc_dec_idle", int'(sc_dec), 0);
      end
      prev_tick = tick;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got %0d exp %0d", 1, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();

    // single inc pulse at prescaler count 3
    idle(3);
    run_cycle(1, 0);
    idle(30);

    // both requests held at level 10
    drive_until(1, 0, 10);
    for (int i = 0; i < 3 * TD; i++) run_cycle(1, 1);

    // hysteresis around TENSE
    drive_until(1, 0, 64);
    for (int i = 0; i < 2 * TD; i++) run_cycle(1, 0);
    drive_until(0, 1, 57);
    for (int i = 0; i < 2 * TD; i++) run_cycle(1, 1);
    drive_until(0, 1, 55);
    for (int i = 0; i < 2 * TD; i++) run_cycle(1, 1);

    // saturation at both ends, via all four moods
    drive_until(1, 0, MAXL);
    for (int i = 0; i < 5 * TD; i++) run_cycle(1, 0);
    drive_until(0, 1, 0);
    for (int i = 0; i < 5 * TD; i++) run_cycle(0, 1);

    // idle decay window and its restart by a request
    drive_until(1, 0, 5);
    idle(6 * TD);
    idle(2 * TD + 5);
    run_cycle(1, 0);
    idle(6 * TD);

    // randomized traffic with one mid-run reset
    for (int blk = 0; blk < 60; blk++) begin
      int mode = $urandom_range(0, 3);
      if (blk == 30) begin
        while (ph != 5) run_cycle(0, 0);
        run_cycle(1, 0);
        do_reset();
        idle(TD + 4);
      end
      for (int i = 0; i < 64; i++) begin
        bit a, b;
        case (mode)
          0: begin a = 0; b = 0; end
          1: begin a = ($urandom_range(0, 3) != 0); b = ($urandom_range(0, 7) == 0); end
          2: begin a = ($urandom_range(0, 7) == 0); b = ($urandom_range(0, 3) == 0); end
          default: begin a = ($urandom_range(0, 9) == 0); b = ($urandom_range(0, 9) == 0); end
        endcase
        run_cycle(a, b);
      end
    end

    idle(2 * TD + 4);
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
